// File: rtl/pipe_defs.sv
// -----------------------------------------------------------------------------
// pipe_defs
//   Shared definitions for the instruction-fetch stage.
//   - PIPE_RESET_PC / PIPE_NOP_INSTR : default parameter values
//   - fetch_state_e                   : fetch FSM encoding (FETCH/DRAIN/HOLD)
//   - word_align()                    : clears the two byte-offset bits of an address
// -----------------------------------------------------------------------------
package pipe_defs;

  localparam logic [31:0] PIPE_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP        = 32'd4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request outstanding, result will be used
    ST_DRAIN = 2'd1,  // request outstanding, result will be thrown away
    ST_HOLD  = 2'd2   // no request, fetched word parked in the skid register
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
//   Instruction-memory request/acknowledge port.
//   imem_req   : fetch request; imem_addr is valid while high
//   imem_addr  : word-aligned fetch address
//   imem_ack   : read data valid this cycle (meaningful only while imem_req=1)
//   imem_rdata : instruction word, valid with imem_ack
//   master = fetch stage side, slave = memory side.
// -----------------------------------------------------------------------------
interface if_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register.
//   Priority on every edge: Reset > i_flush > i_hold > i_load > bubble.
//     flush : instr=NOP_INSTR, pc4=0, valid=0
//     hold  : keep current contents
//     load  : capture {i_instr, i_pc4}, valid=1
//     bubble: instr=NOP_INSTR, valid=0, pc4 unchanged
// Ports
//   Clk, Reset          : clock, synchronous active-high reset
//   i_flush/i_hold/i_load : update controls
//   i_instr, i_pc4      : data to load
//   o_instr, o_pc4, o_valid : register contents
// -----------------------------------------------------------------------------
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        i_flush,
  input  logic        i_hold,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
    end else if (i_hold) begin
      r_instr <= r_instr;
      r_pc4   <= r_pc4;
      r_valid <= r_valid;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end else begin
      // Bubble: pc4 intentionally left as-is.
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage: owns the PC, drives a req/ack instruction memory
//   port, tolerates any memory latency, honours load-use stalls (hazard) and
//   taken-branch redirects (BranchBubble). An issued fetch is never cancelled:
//   a redirect while a fetch is pending waits for its ack in DRAIN and throws
//   the word away; a stall arriving with an ack parks the word in a skid
//   register (HOLD) so nothing is lost.
// Ports
//   Clk, Reset    : clock, synchronous active-high reset
//   hazard        : hold PC and IF/ID
//   BranchBubble  : redirect PC to br_target, flush IF/ID (beats hazard)
//   br_target     : redirect address (low two bits ignored)
//   imem          : instruction memory port (master side)
//   id_instr, id_pc4, id_valid : IF/ID register outputs
//   if_busy       : no instruction delivered this cycle
// -----------------------------------------------------------------------------
module if_stage
  import pipe_defs::*;
#(
  parameter logic [31:0] RESET_PC  = PIPE_RESET_PC,
  parameter logic [31:0] NOP_INSTR = PIPE_NOP_INSTR
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         hazard,
  input  logic         BranchBubble,
  input  logic [31:0]  br_target,
  if_stage_if.master   imem,
  output logic [31:0]  id_instr,
  output logic [31:0]  id_pc4,
  output logic         id_valid,
  output logic         if_busy
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  r_skid;
  logic [31:0]  w_skid_next;
  logic [31:0]  r_skid_pc4;
  logic [31:0]  w_skid_pc4_next;
  logic [31:0]  r_saved_tgt;
  logic [31:0]  w_saved_tgt_next;

  logic         w_req;
  logic         w_ack;
  logic [31:0]  w_pc4;
  logic [31:0]  w_br_tgt;

  logic         w_ifid_flush;
  logic         w_ifid_hold;
  logic         w_ifid_load;
  logic [31:0]  w_load_instr;
  logic [31:0]  w_load_pc4;

  // A request is outstanding in every state except HOLD.
  assign w_req    = (r_state != ST_HOLD);
  assign w_ack    = imem.imem_ack & w_req;
  assign w_pc4    = r_pc + PC_STEP;
  assign w_br_tgt = word_align(br_target);

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;

  assign if_busy = ((r_state == ST_FETCH) & ~imem.imem_ack) | (r_state == ST_DRAIN);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_skid      <= NOP_INSTR;
      r_skid_pc4  <= 32'd0;
      r_saved_tgt <= RESET_PC;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_skid      <= w_skid_next;
      r_skid_pc4  <= w_skid_pc4_next;
      r_saved_tgt <= w_saved_tgt_next;
    end
  end

  // Next-state, PC and IF/ID control.
  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_skid_next      = r_skid;
    w_skid_pc4_next  = r_skid_pc4;
    w_saved_tgt_next = r_saved_tgt;
    w_ifid_flush     = 1'b0;
    w_ifid_hold      = 1'b0;
    w_ifid_load      = 1'b0;
    w_load_instr     = r_skid;
    w_load_pc4       = r_skid_pc4;

    case (r_state)
      ST_FETCH: begin
        if (BranchBubble) begin
          w_ifid_flush = 1'b1;
          if (w_ack) begin
            w_pc_next = w_br_tgt;
          end else begin
            // Fetch still in flight: remember where to go once it lands.
            w_saved_tgt_next = w_br_tgt;
            w_state_next     = ST_DRAIN;
          end
        end else if (w_ack) begin
          w_pc_next = w_pc4;
          if (hazard) begin
            w_skid_next     = imem.imem_rdata;
            w_skid_pc4_next = w_pc4;
            w_ifid_hold     = 1'b1;
            w_state_next    = ST_HOLD;
          end else begin
            w_ifid_load  = 1'b1;
            w_load_instr = imem.imem_rdata;
            w_load_pc4   = w_pc4;
          end
        end else begin
          w_ifid_hold = hazard;
        end
      end

      ST_DRAIN: begin
        if (BranchBubble) begin
          w_ifid_flush     = 1'b1;
          w_saved_tgt_next = w_br_tgt;
        end else begin
          w_ifid_hold = hazard;
        end
        if (w_ack) begin
          // The newest redirect wins if it coincides with the ack.
          w_pc_next    = BranchBubble ? w_br_tgt : r_saved_tgt;
          w_state_next = ST_FETCH;
        end
      end

      ST_HOLD: begin
        if (BranchBubble) begin
          w_ifid_flush = 1'b1;
          w_pc_next    = w_br_tgt;
          w_state_next = ST_FETCH;
        end else if (hazard) begin
          w_ifid_hold = 1'b1;
        end else begin
          w_ifid_load  = 1'b1;
          w_state_next = ST_FETCH;
        end
      end

      default: begin
        w_state_next = ST_FETCH;
      end
    endcase
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_flush (w_ifid_flush),
    .i_hold  (w_ifid_hold),
    .i_load  (w_ifid_load),
    .i_instr (w_load_instr),
    .i_pc4   (w_load_pc4),
    .o_instr (id_instr),
    .o_pc4   (id_pc4),
    .o_valid (id_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
//   Directed bench for if_stage. Inputs change 1 time unit after a rising
//   edge; combinational outputs are checked 1 unit after that, registered
//   outputs 1 unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_if_stage;

  logic        Clk;
  logic        Reset;
  logic        hazard;
  logic        BranchBubble;
  logic [31:0] br_target;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        if_busy;

  int n_vec;
  int n_err;

  if_stage_if imem_bus ();

  if_stage dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .hazard       (hazard),
    .BranchBubble (BranchBubble),
    .br_target    (br_target),
    .imem         (imem_bus),
    .id_instr     (id_instr),
    .id_pc4       (id_pc4),
    .id_valid     (id_valid),
    .if_busy      (if_busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ei, input logic [31:0] ep, input logic ev);
    chk({tag, "_instr"}, id_instr, ei);
    chk({tag, "_pc4"}, id_pc4, ep);
    chk({tag, "_valid"}, {31'd0, id_valid}, {31'd0, ev});
  endtask

  task automatic chk_port(input string tag, input logic er, input logic [31:0] ea, input logic eb);
    chk({tag, "_req"}, {31'd0, imem_bus.imem_req}, {31'd0, er});
    if (er) chk({tag, "_addr"}, imem_bus.imem_addr, ea);
    chk({tag, "_busy"}, {31'd0, if_busy}, {31'd0, eb});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset = 1'b1; hazard = 1'b0; BranchBubble = 1'b0; br_target = 32'd0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'd0;

    // Reset values
    cyc(); cyc();
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    Reset = 1'b0; #1;
    chk_port("rst_port", 1'b1, 32'h0, 1'b1);

    // Ack every cycle from 0
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hA000_0000; #1;
    chk_port("b2b0_port", 1'b1, 32'h0, 1'b0);
    cyc(); chk_ifid("b2b0", 32'hA000_0000, 32'h4, 1'b1);
    imem_bus.imem_rdata = 32'hA000_0004; #1;
    chk_port("b2b1_port", 1'b1, 32'h4, 1'b0);
    cyc(); chk_ifid("b2b1", 32'hA000_0004, 32'h8, 1'b1);
    imem_bus.imem_rdata = 32'hA000_0008; #1;
    chk_port("b2b2_port", 1'b1, 32'h8, 1'b0);
    cyc(); chk_ifid("b2b2", 32'hA000_0008, 32'hC, 1'b1);

    // Ack arrives on the third cycle of the request
    imem_bus.imem_ack = 1'b0; #1;
    chk_port("lat1_port", 1'b1, 32'hC, 1'b1);
    cyc(); chk_ifid("lat1", 32'h0, 32'hC, 1'b0);
    #1; chk_port("lat2_port", 1'b1, 32'hC, 1'b1);
    cyc(); chk_ifid("lat2", 32'h0, 32'hC, 1'b0);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hB000_000C; #1;
    chk_port("lat3_port", 1'b1, 32'hC, 1'b0);
    cyc(); chk_ifid("lat3", 32'hB000_000C, 32'h10, 1'b1);

    // Stall for two cycles while the ack arrives
    hazard = 1'b1; imem_bus.imem_rdata = 32'hC000_0010;
    cyc(); chk_ifid("haz1", 32'hB000_000C, 32'h10, 1'b1);
    imem_bus.imem_ack = 1'b0; #1;
    chk_port("haz1_port", 1'b0, 32'h0, 1'b0);
    cyc(); chk_ifid("haz2", 32'hB000_000C, 32'h10, 1'b1);
    hazard = 1'b0;
    cyc(); chk_ifid("haz_rel", 32'hC000_0010, 32'h14, 1'b1);
    #1; chk_port("haz_rel_port", 1'b1, 32'h14, 1'b1);

    // Redirect while fetch at 0x14 pending; low target bits ignored
    BranchBubble = 1'b1; br_target = 32'h0000_0043;
    cyc(); chk_ifid("br_flush", 32'h0, 32'h0, 1'b0);
    BranchBubble = 1'b0; #1;
    chk_port("drain1_port", 1'b1, 32'h14, 1'b1);
    cyc(); chk_ifid("drain1", 32'h0, 32'h0, 1'b0);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF; #1;
    chk_port("drain_ack_port", 1'b1, 32'h14, 1'b1);
    cyc(); chk_ifid("drain_ack", 32'h0, 32'h0, 1'b0);
    imem_bus.imem_ack = 1'b0; #1;
    chk_port("br_tgt_port", 1'b1, 32'h40, 1'b1);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hD000_0040;
    cyc(); chk_ifid("br_tgt", 32'hD000_0040, 32'h44, 1'b1);

    // Branch and stall together with an ack
    hazard = 1'b1; BranchBubble = 1'b1; br_target = 32'h80; imem_bus.imem_rdata = 32'hEEEE_EEEE;
    cyc(); chk_ifid("br_haz", 32'h0, 32'h0, 1'b0);
    BranchBubble = 1'b0; imem_bus.imem_ack = 1'b0; #1;
    chk_port("br_haz_port", 1'b1, 32'h80, 1'b1);

    // Branch out of HOLD drops the parked word
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hE000_0080;
    cyc(); chk_ifid("hold_in", 32'h0, 32'h0, 1'b0);
    imem_bus.imem_ack = 1'b0; #1;
    chk_port("hold_port", 1'b0, 32'h0, 1'b0);
    BranchBubble = 1'b1; br_target = 32'h100;
    cyc(); chk_ifid("hold_br", 32'h0, 32'h0, 1'b0);
    BranchBubble = 1'b0; hazard = 1'b0; #1;
    chk_port("hold_br_port", 1'b1, 32'h100, 1'b1);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hE000_0100;
    cyc(); chk_ifid("hold_br_f", 32'hE000_0100, 32'h104, 1'b1);
    imem_bus.imem_ack = 1'b0;
    cyc(); chk_ifid("skid_drop", 32'h0, 32'h104, 1'b0);

    // PC wrap at 0xFFFFFFFC
    BranchBubble = 1'b1; br_target = 32'hFFFF_FFFF;
    cyc();
    BranchBubble = 1'b0; imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h1234_5678;
    cyc();
    imem_bus.imem_ack = 1'b0; #1;
    chk_port("wrap_port", 1'b1, 32'hFFFF_FFFC, 1'b1);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hF000_FFFC;
    cyc(); chk_ifid("wrap", 32'hF000_FFFC, 32'h0, 1'b1);
    imem_bus.imem_ack = 1'b0; #1;
    chk_port("wrap0_port", 1'b1, 32'h0, 1'b1);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hF000_0000;
    cyc(); chk_ifid("wrap_next", 32'hF000_0000, 32'h4, 1'b1);

    // Reset while the fetch at 0x4 is outstanding
    imem_bus.imem_ack = 1'b0;
    cyc(); chk_ifid("pend", 32'h0, 32'h4, 1'b0);
    Reset = 1'b1;
    cyc(); chk_ifid("mid_rst", 32'h0, 32'h0, 1'b0);
    Reset = 1'b0; #1;
    chk_port("mid_rst_port", 1'b1, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
